// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
//   Shared definitions for the digit scan sequencer: FSM state type, default
//   parameter values and the cyclic "next enabled index" search.
// -----------------------------------------------------------------------------
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } scan_state_e;

  localparam int DEF_SEL_W     = 2;
  localparam int DEF_DWELL     = 4;
  localparam int DEF_BLANK_CYC = 1;

  // Widest select the search helper supports; callers zero-extend into it.
  localparam int MAX_SEL_W = 5;
  localparam int MAX_N     = 32;

  // Cyclic priority pick: first set bit of mask strictly above cur, wrapping
  // from n-1 to 0, with cur itself checked last. Iterating from the far end
  // lets the nearest hit overwrite earlier ones. Returns cur if mask is empty.
  function automatic logic [MAX_SEL_W-1:0] next_enabled(
    input logic [MAX_N-1:0]     mask,
    input logic [MAX_SEL_W-1:0] cur,
    input int                   n
  );
    logic [MAX_SEL_W-1:0] pick;
    int                   idx;
    pick = cur;
    for (int i = n; i >= 1; i--) begin
      idx = (int'(cur) + i) % n;
      if (mask[idx[MAX_SEL_W-1:0]]) begin
        pick = idx[MAX_SEL_W-1:0];
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/onehot_shift_dec.sv
// -----------------------------------------------------------------------------
// onehot_shift_dec
//   Binary-to-one-hot shift decoder: onehot = 1 << idx.
//   Ports:
//     idx     in   SEL_W        binary index
//     onehot  out  1<<SEL_W     decoded one-hot word
// -----------------------------------------------------------------------------
module onehot_shift_dec #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [(1<<SEL_W)-1:0] onehot
);

  localparam int N = 1 << SEL_W;

  assign onehot = N'(1) << idx;

endmodule

// File: rtl/digit_scan_sequencer.sv
// -----------------------------------------------------------------------------
// digit_scan_sequencer
//   Time-multiplexed select generator. Steps a binary select index through the
//   mask-enabled outputs, holding each for DWELL cycles with BLANK_CYC cycles of
//   blanking in between, and also presents the decoded one-hot select.
//   Ports:
//     clk         in   1      rising-edge clock
//     rst         in   1      synchronous active-high reset
//     en          in   1      run enable; low forces IDLE
//     mask        in   N      per-index scan enable
//     sel         out  SEL_W  current select index (registered)
//     onehot      out  N      1<<sel while ACTIVE, else zero (registered)
//     blank       out  1      high whenever onehot is zero (registered)
//     frame_done  out  1      one-cycle pulse when the scan wraps (registered)
// -----------------------------------------------------------------------------
module digit_scan_sequencer
  import scan_pkg::*;
#(
  parameter int SEL_W     = DEF_SEL_W,
  parameter int DWELL     = DEF_DWELL,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [(1<<SEL_W)-1:0] mask,
  output logic [SEL_W-1:0]      sel,
  output logic [(1<<SEL_W)-1:0] onehot,
  output logic                  blank,
  output logic                  frame_done
);

  localparam int N         = 1 << SEL_W;
  localparam int MAX_CYC   = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int CNT_W     = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);
  localparam bit HAS_BLANK = (BLANK_CYC > 0);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = HAS_BLANK ? CNT_W'(BLANK_CYC - 1) : '0;

  scan_state_e          state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [MAX_N-1:0]     mask_ext_s;
  logic [MAX_SEL_W-1:0] sel_ext_s;
  logic [MAX_SEL_W-1:0] pick_s;
  logic [SEL_W-1:0]     target_s;
  logic [N-1:0]         dec_s;
  logic                 mask_any_s;

  // Index to enter next: lowest set bit from IDLE, else next set bit above sel.
  always_comb begin
    mask_ext_s            = '0;
    mask_ext_s[N-1:0]     = mask;
    sel_ext_s             = '0;
    sel_ext_s[SEL_W-1:0]  = sel;
    mask_any_s            = |mask;
    if (state_r == IDLE) begin
      // Searching from N-1 makes index 0 the first candidate.
      pick_s = next_enabled(mask_ext_s, MAX_SEL_W'(N - 1), N);
    end else begin
      pick_s = next_enabled(mask_ext_s, sel_ext_s, N);
    end
    target_s = pick_s[SEL_W-1:0];
  end

  onehot_shift_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .idx    (target_s),
    .onehot (dec_s)
  );

  // Scan FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      sel        <= '0;
      onehot     <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else if (!en) begin
      // sel deliberately holds its last value while disabled.
      state_r    <= IDLE;
      cnt_r      <= '0;
      onehot     <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (mask_any_s) begin
            state_r <= ACTIVE;
            sel     <= target_s;
            onehot  <= dec_s;
            blank   <= 1'b0;
          end else begin
            onehot <= '0;
            blank  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cnt_r == DWELL_LAST) begin
            cnt_r <= '0;
            if (HAS_BLANK) begin
              state_r <= BLANK;
              onehot  <= '0;
              blank   <= 1'b1;
            end else if (!mask_any_s) begin
              state_r <= IDLE;
              onehot  <= '0;
              blank   <= 1'b1;
            end else begin
              // Without blanking the advance happens straight out of ACTIVE.
              sel        <= target_s;
              onehot     <= dec_s;
              frame_done <= (target_s <= sel);
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            cnt_r <= '0;
            if (!mask_any_s) begin
              state_r <= IDLE;
              onehot  <= '0;
              blank   <= 1'b1;
            end else begin
              state_r    <= ACTIVE;
              sel        <= target_s;
              onehot     <= dec_s;
              blank      <= 1'b0;
              frame_done <= (target_s <= sel);
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          onehot  <= '0;
          blank   <= 1'b1;
        end
      endcase
    end
  end

endmodule
